mc_control_fsm: RTL

Multicycle control unit for the RV32I core: sequences fetch, decode, execute, memory and writeback for each instruction, and drives the ALU operation code and all datapath select and strobe signals. It is the producer side of the ALU interface. It issues `alu_operation`, consumes the ALU `zero` flag to resolve branches, and owns the memory request handshake.

---
 rtl/mc_control_fsm_if.sv | 30 +++
 rtl/mc_control_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm_if.sv
// Control bundle between the multicycle sequencer (master) and the RV32I datapath (slave).
interface mc_control_fsm_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic [3:0]  alu_operation;
  logic [1:0]  alu_src_a;
  logic [1:0]  alu_src_b;
  logic        pc_write;
  logic        pc_src;
  logic        ir_write;
  logic        mem_req;
  logic        mem_we;
  logic        mem_addr_sel;
  logic        reg_write;
  logic [1:0]  result_src;
  logic        trap;

  modport master (
    input  instr, zero, mem_ready,
    output alu_operation, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_req, mem_we, mem_addr_sel, reg_write, result_src, trap
  );

  modport slave (
    output instr, zero, mem_ready,
    input  alu_operation, alu_src_a, alu_src_b, pc_write, pc_src, ir_write,
           mem_req, mem_we, mem_addr_sel, reg_write, result_src, trap
  );
endinterface

// File: rtl/mc_control_fsm.sv
// Multicycle RV32I control sequencer: fetch/decode/execute/memory/writeback, ALU op select,
// branch resolution from the ALU zero flag, and the memory request handshake.
module mc_control_fsm (
  input  logic               clk,
  input  logic               reset,
  mc_control_fsm_if.master   bus
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_LUI, S_AUIPC, S_ALU_WB,
    S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  state_t state, next_state;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr_bits;

  assign opcode = bus.instr[6:0];
  assign funct3 = bus.instr[14:12];
  assign funct7 = bus.instr[31:25];
  assign unused_instr_bits = ^{bus.instr[24:15], bus.instr[11:7]};

  // Returns {illegal, op}. I-type differs only in funct3 000 (no SUB) and in
  // leaving funct7 unchecked where those bits are immediate.
  function automatic logic [4:0] alu_decode(input logic [2:0] f3, input logic [6:0] f7,
                                            input logic is_r);
    logic [3:0] op;
    logic       bad;
    op  = ALU_ADD;
    bad = 1'b0;
    case (f3)
      3'b000: begin
        if (!is_r || f7 == F7_BASE) op = ALU_ADD;
        else if (f7 == F7_ALT)      op = ALU_SUB;
        else                        bad = 1'b1;
      end
      3'b001: begin op = ALU_SLL;  bad = (f7 != F7_BASE); end
      3'b010: begin op = ALU_SLT;  bad = is_r && (f7 != F7_BASE); end
      3'b011: begin op = ALU_SLTU; bad = is_r && (f7 != F7_BASE); end
      3'b100: begin op = ALU_XOR;  bad = is_r && (f7 != F7_BASE); end
      3'b101: begin
        if (f7 == F7_BASE)     op = ALU_SRL;
        else if (f7 == F7_ALT) op = ALU_SRA;
        else                   bad = 1'b1;
      end
      3'b110: begin op = ALU_OR;   bad = is_r && (f7 != F7_BASE); end
      default: begin op = ALU_AND; bad = is_r && (f7 != F7_BASE); end
    endcase
    return {bad, op};
  endfunction

  logic [3:0] alu_op_c;
  logic [1:0] src_a_c, src_b_c, result_src_c;
  logic       pc_write_c, pc_src_c, ir_write_c, mem_req_c, mem_we_c, mem_addr_sel_c, reg_write_c;
  logic [4:0] dec;
  logic       taken;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state     = state;
    alu_op_c       = ALU_ADD;
    src_a_c        = 2'd0;
    src_b_c        = 2'd0;
    result_src_c   = 2'd0;
    pc_write_c     = 1'b0;
    pc_src_c       = 1'b0;
    ir_write_c     = 1'b0;
    mem_req_c      = 1'b0;
    mem_we_c       = 1'b0;
    mem_addr_sel_c = 1'b0;
    reg_write_c    = 1'b0;
    dec            = 5'd0;
    taken          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req_c = 1'b1;
        src_a_c   = 2'd1;
        src_b_c   = 2'd2;
        if (bus.mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        src_a_c = 2'd2;
        src_b_c = 2'd1;
        case (opcode)
          7'b0110011: next_state = S_EXEC_R;
          7'b0010011: next_state = S_EXEC_I;
          7'b0000011,
          7'b0100011: next_state = S_MEM_ADDR;
          7'b1100011: next_state = S_BRANCH;
          7'b1101111: next_state = S_JAL;
          7'b1100111: next_state = S_JALR;
          7'b0110111: next_state = S_LUI;
          7'b0010111: next_state = S_AUIPC;
          default:    next_state = S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        dec        = alu_decode(funct3, funct7, 1'b1);
        alu_op_c   = dec[3:0];
        next_state = dec[4] ? S_TRAP : S_ALU_WB;
      end
      S_EXEC_I: begin
        src_b_c    = 2'd1;
        dec        = alu_decode(funct3, funct7, 1'b0);
        alu_op_c   = dec[3:0];
        next_state = dec[4] ? S_TRAP : S_ALU_WB;
      end
      S_LUI: begin
        src_a_c    = 2'd3;
        src_b_c    = 2'd1;
        next_state = S_ALU_WB;
      end
      S_AUIPC: begin
        src_a_c    = 2'd2;
        src_b_c    = 2'd1;
        next_state = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write_c = 1'b1;
        next_state  = S_FETCH;
      end
      S_MEM_ADDR: begin
        src_b_c    = 2'd1;
        next_state = opcode[5] ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req_c      = 1'b1;
        mem_addr_sel_c = 1'b1;
        if (bus.mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write_c  = 1'b1;
        result_src_c = 2'd1;
        next_state   = S_FETCH;
      end
      S_MEM_WR: begin
        mem_req_c      = 1'b1;
        mem_we_c       = 1'b1;
        mem_addr_sel_c = 1'b1;
        if (bus.mem_ready) next_state = S_FETCH;
      end
      S_BRANCH: begin
        pc_src_c   = 1'b1;
        next_state = S_FETCH;
        // funct3[0] inverts the sense; SLT/SLTU put the compare result on zero.
        taken = funct3[0] ? !bus.zero : bus.zero;
        case (funct3[2:1])
          2'b00:   alu_op_c = ALU_SUB;
          2'b10:   alu_op_c = ALU_SLT;
          2'b11:   alu_op_c = ALU_SLTU;
          default: begin
            taken      = 1'b0;
            next_state = S_TRAP;
          end
        endcase
        pc_write_c = taken;
      end
      S_JAL: begin
        pc_write_c   = 1'b1;
        pc_src_c     = 1'b1;
        reg_write_c  = 1'b1;
        result_src_c = 2'd2;
        next_state   = S_FETCH;
      end
      S_JALR: begin
        src_b_c      = 2'd1;
        pc_write_c   = 1'b1;
        reg_write_c  = 1'b1;
        result_src_c = 2'd2;
        next_state   = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_FETCH;
    endcase
  end

  // Everything is held at zero while reset is high so an abort leaves no partial write.
  assign bus.alu_operation = reset ? 4'd0 : alu_op_c;
  assign bus.alu_src_a     = reset ? 2'd0 : src_a_c;
  assign bus.alu_src_b     = reset ? 2'd0 : src_b_c;
  assign bus.result_src    = reset ? 2'd0 : result_src_c;
  assign bus.pc_write      = !reset && pc_write_c;
  assign bus.pc_src        = !reset && pc_src_c;
  assign bus.ir_write      = !reset && ir_write_c;
  assign bus.mem_req       = !reset && mem_req_c;
  assign bus.mem_we        = !reset && mem_we_c;
  assign bus.mem_addr_sel  = !reset && mem_addr_sel_c;
  assign bus.reg_write     = !reset && reg_write_c;
  assign bus.trap          = !reset && (state == S_TRAP);

endmodule
